// File: rtl/geo_pkg.sv
// Shared types for the pixel writer: pixel-depth encoding, FSM states,
// clip counter width and the per-depth pixel mask helpers.
package geo_pkg;

  typedef enum logic [1:0] {
    BPP_1 = 2'd0,
    BPP_2 = 2'd1,
    BPP_4 = 2'd2,
    BPP_8 = 2'd3
  } bpp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam int unsigned CLIP_W  = 16;
  localparam int unsigned COORD_W = 12;

  // Right-aligned mask covering one pixel of the given depth.
  function automatic logic [7:0] pix_mask(input bpp_e b);
    logic [7:0] m;
    case (b)
      BPP_1:   m = 8'h01;
      BPP_2:   m = 8'h03;
      BPP_4:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] pix_width(input bpp_e b);
    return 4'd1 << b;
  endfunction

endpackage

// File: rtl/geo_pixel_writer_if.sv
// Memory write port of the pixel writer: request/ready handshake plus
// byte address, data and bit mask.
interface geo_pixel_writer_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic              wr_req;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        wr_mask;

  modport master (
    output wr_req, wr_addr, wr_data, wr_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_mask,
    output wr_ready
  );
endinterface

// File: rtl/geo_coord_fifo.sv
// Coordinate buffer: power-of-two depth FIFO, registered storage, no
// write-to-read bypass (a pushed entry is visible the following cycle).
module geo_coord_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/geo_pixel_writer.sv
// Turns a stream of signed pixel coordinates into masked byte writes into a
// packed MSB-first bitmap, clipping against inclusive limits.
module geo_pixel_writer
  import geo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pixel_in_rdy,
  input  logic signed [COORD_W-1:0] x_in,
  input  logic signed [COORD_W-1:0] y_in,
  input  logic                      line_complete_in,
  output logic                      pause_out,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [15:0]               row_stride,
  input  logic [1:0]                bpp_sel,
  input  logic [7:0]                color,
  input  logic [COORD_W-1:0]        max_x,
  input  logic [COORD_W-1:0]        max_y,
  geo_pixel_writer_if.master        wr_bus,
  output logic                      busy,
  output logic                      done,
  output logic [CLIP_W-1:0]         clip_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e state, state_nxt;

  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic [2*COORD_W-1:0]     fifo_q;

  logic signed [COORD_W-1:0] x_r, y_r;
  logic                      wr_req_r;
  logic [ADDR_W-1:0]         addr_r;
  logic [7:0]                data_r, mask_r;
  logic                      pending;
  logic                      load_xy;
  logic                      xfer;
  logic                      done_cond;

  geo_coord_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*COORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pixel_in_rdy && !fifo_full),
    .push_data ({x_in, y_in}),
    .pop       (fifo_pop),
    .pop_data  (fifo_q),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pause_out = (fifo_count == CNT_W'(FIFO_DEPTH));

  // Address and mask arithmetic on the registered coordinate.
  bpp_e                bpp;
  logic                clipped;
  logic [14:0]         x_bits;
  logic [2:0]          bo;
  logic [3:0]          shamt;
  logic [ADDR_W-1:0]   addr_calc;

  assign bpp     = bpp_e'(bpp_sel);
  assign clipped = x_r[COORD_W-1] || y_r[COORD_W-1] ||
                   (x_r[COORD_W-1:0] > max_x) || (y_r[COORD_W-1:0] > max_y);
  assign x_bits  = 15'(x_r[COORD_W-2:0]) << bpp_sel;
  assign bo      = x_bits[2:0];
  // Pixel at bit offset bo sits at bits 7-bo downward, i.e. left-shift by 8-bo-width.
  assign shamt   = 4'd8 - {1'b0, bo} - pix_width(bpp);
  assign addr_calc = base_addr
                   + ADDR_W'(y_r[COORD_W-2:0]) * ADDR_W'(row_stride)
                   + ADDR_W'(x_bits[14:3]);

  assign xfer      = wr_req_r && wr_bus.wr_ready;
  assign done_cond = pending && fifo_empty && (state == IDLE) && !wr_req_r;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_xy   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_xy   = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        state_nxt = clipped ? IDLE : ISSUE;
      end
      ISSUE: begin
        if (xfer) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            load_xy   = 1'b1;
            state_nxt = CALC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r        <= '0;
      y_r        <= '0;
      wr_req_r   <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      mask_r     <= '0;
      clip_count <= '0;
      pending    <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (load_xy) begin
        {x_r, y_r} <= fifo_q;
      end
      if (state == CALC) begin
        if (clipped) begin
          if (clip_count != '1) clip_count <= clip_count + 1'b1;
        end else begin
          wr_req_r <= 1'b1;
          addr_r   <= addr_calc;
          mask_r   <= pix_mask(bpp) << shamt;
          data_r   <= (color & pix_mask(bpp)) << shamt;
        end
      end
      if (state == ISSUE && xfer) begin
        wr_req_r <= 1'b0;
      end
      done <= done_cond;
      if (line_complete_in)  pending <= 1'b1;
      else if (done_cond)    pending <= 1'b0;
    end
  end

  assign busy           = !fifo_empty || (state != IDLE) || pending;
  assign wr_bus.wr_req  = wr_req_r;
  assign wr_bus.wr_addr = addr_r;
  assign wr_bus.wr_data = data_r;
  assign wr_bus.wr_mask = mask_r;

endmodule

// File: tb/tb_geo_pixel_writer.sv
// Scoreboard bench for geo_pixel_writer: directed pixels push expected writes,
// a negedge monitor pops and compares every accepted write.
module tb_geo_pixel_writer;
  import geo_pkg::*;

  localparam int unsigned AW = 20;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      pixel_in_rdy;
  logic signed [COORD_W-1:0] x_in, y_in;
  logic                      line_complete_in;
  logic                      pause_out;
  logic [AW-1:0]             base_addr;
  logic [15:0]               row_stride;
  logic [1:0]                bpp_sel;
  logic [7:0]                color;
  logic [COORD_W-1:0]        max_x, max_y;
  logic                      busy, done;
  logic [CLIP_W-1:0]         clip_count;

  always #5 clk = ~clk;

  geo_pixel_writer_if #(.ADDR_W(AW)) wr_bus ();

  geo_pixel_writer #(
    .FIFO_DEPTH (4),
    .ADDR_W     (AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_in_rdy     (pixel_in_rdy),
    .x_in             (x_in),
    .y_in             (y_in),
    .line_complete_in (line_complete_in),
    .pause_out        (pause_out),
    .base_addr        (base_addr),
    .row_stride       (row_stride),
    .bpp_sel          (bpp_sel),
    .color            (color),
    .max_x            (max_x),
    .max_y            (max_y),
    .wr_bus           (wr_bus),
    .busy             (busy),
    .done             (done),
    .clip_count       (clip_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [7:0]    mask;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_writes = 0;
  int  n_done   = 0;
  int  writes_at_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: scoreboard pop on each transfer, hold-stability while stalled, done tracking.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_data, prev_mask;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_stall) begin
          check("hold_req",  wr_bus.wr_req,  1);
          check("hold_addr", wr_bus.wr_addr, prev_addr);
          check("hold_data", wr_bus.wr_data, prev_data);
          check("hold_mask", wr_bus.wr_mask, prev_mask);
        end
        if (wr_bus.wr_req && wr_bus.wr_ready) begin
          n_writes++;
          check("write_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", wr_bus.wr_addr, e.addr);
            check("wr_data", wr_bus.wr_data, e.data);
            check("wr_mask", wr_bus.wr_mask, e.mask);
          end
        end
        if (done) begin
          n_done++;
          writes_at_done = n_writes;
        end
      end
      prev_stall = !reset && wr_bus.wr_req && !wr_bus.wr_ready;
      prev_addr  = wr_bus.wr_addr;
      prev_data  = wr_bus.wr_data;
      prev_mask  = wr_bus.wr_mask;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [AW-1:0] b, input logic [15:0] s, input logic [1:0] bp,
                         input logic [7:0] c, input int mx, input int my);
    base_addr  = b;
    row_stride = s;
    bpp_sel    = bp;
    color      = c;
    max_x      = COORD_W'(mx);
    max_y      = COORD_W'(my);
  endtask

  task automatic push_px(input int x, input int y);
    int n = 0;
    while (pause_out && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("pause_wait", pause_out, 0);
    pixel_in_rdy = 1'b1;
    x_in = COORD_W'(x);
    y_in = COORD_W'(y);
    tick();
    pixel_in_rdy = 1'b0;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d, input logic [7:0] m);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || wr_bus.wr_req) && n < 200) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    int n;
    int w0;
    int d0;
    reset = 1'b1;
    pixel_in_rdy = 1'b0;
    x_in = '0;
    y_in = '0;
    line_complete_in = 1'b0;
    wr_bus.wr_ready = 1'b1;
    set_cfg(20'h0, 16'd0, 2'd0, 8'h0, 1000, 1000);
    tick();
    tick();
    reset = 1'b0;

    check("rst_wr_req",  wr_bus.wr_req, 0);
    check("rst_done",    done, 0);
    check("rst_busy",    busy, 0);
    check("rst_pause",   pause_out, 0);
    check("rst_clip",    clip_count, 0);
    check("rst_wr_addr", wr_bus.wr_addr, 0);
    check("rst_wr_data", wr_bus.wr_data, 0);
    check("rst_wr_mask", wr_bus.wr_mask, 0);

    // 8bpp latency vector
    set_cfg(20'h1000, 16'd640, 2'd3, 8'hA5, 1000, 1000);
    expect_wr(20'h1503, 8'hA5, 8'hFF);
    pixel_in_rdy = 1'b1;
    x_in = 12'sd3;
    y_in = 12'sd2;
    tick();
    pixel_in_rdy = 1'b0;
    check("lat_c1", wr_bus.wr_req, 0);
    tick();
    check("lat_c2", wr_bus.wr_req, 0);
    tick();
    check("lat_c3", wr_bus.wr_req, 1);
    wait_idle("idle_8bpp");

    // 1bpp
    set_cfg(20'h2000, 16'd80, 2'd0, 8'h01, 1000, 1000);
    expect_wr(20'h2001, 8'h20, 8'h20);
    expect_wr(20'h2000, 8'h01, 8'h01);
    push_px(10, 0);
    push_px(7, 0);
    wait_idle("idle_1bpp");

    // 2bpp
    set_cfg(20'h2000, 16'd80, 2'd1, 8'h02, 1000, 1000);
    expect_wr(20'h2051, 8'h20, 8'h30);
    push_px(5, 1);
    wait_idle("idle_2bpp");

    // 4bpp, colour upper bits must be discarded
    set_cfg(20'h2000, 16'd80, 2'd2, 8'hF7, 1000, 1000);
    expect_wr(20'h2001, 8'h07, 8'h0F);
    expect_wr(20'h2001, 8'h70, 8'hF0);
    push_px(3, 0);
    push_px(2, 0);
    wait_idle("idle_4bpp");

    // Backpressure: stall memory, fill FIFO, then drain at full rate
    set_cfg(20'h0, 16'd16, 2'd3, 8'h3C, 1000, 1000);
    wr_bus.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_wr(AW'(i), 8'h3C, 8'hFF);
      push_px(i, 0);
    end
    check("pause_full", pause_out, 1);
    check("busy_full",  busy, 1);
    pixel_in_rdy = 1'b1;
    x_in = 12'sd9;
    y_in = 12'sd9;
    tick();
    tick();
    tick();
    pixel_in_rdy = 1'b0;
    check("pause_held", pause_out, 1);
    wr_bus.wr_ready = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("drain_cycles", n, 9);
    check("pause_released", pause_out, 0);
    check("q_empty_bp", exp_q.size(), 0);

    // Clipping and end-of-line
    set_cfg(20'h3000, 16'd100, 2'd3, 8'h5A, 99, 50);
    d0 = n_done;
    expect_wr(20'h3226, 8'h5A, 8'hFF);
    push_px(-1, 5);
    push_px(100, 5);
    push_px(50, 5);
    line_complete_in = 1'b1;
    tick();
    line_complete_in = 1'b0;
    wait_idle("idle_clip");
    tick();
    tick();
    tick();
    check("clip_count_2", clip_count, 2);
    check("done_once", n_done - d0, 1);
    check("done_after_write", writes_at_done, n_writes);

    // Inclusive limits
    expect_wr(20'h43EB, 8'h5A, 8'hFF);
    push_px(99, 50);
    push_px(0, 51);
    wait_idle("idle_limits");
    check("clip_count_3", clip_count, 3);

    // Reset while a write is stalled and the FIFO holds three entries
    set_cfg(20'h0, 16'd16, 2'd3, 8'h11, 1000, 1000);
    wr_bus.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_px(i + 20, 1);
    check("pre_rst_req",   wr_bus.wr_req, 1);
    check("pre_rst_pause", pause_out, 0);
    reset = 1'b1;
    tick();
    check("post_rst_req",   wr_bus.wr_req, 0);
    check("post_rst_busy",  busy, 0);
    check("post_rst_pause", pause_out, 0);
    check("post_rst_clip",  clip_count, 0);
    reset = 1'b0;
    wr_bus.wr_ready = 1'b1;
    w0 = n_writes;
    for (int i = 0; i < 10; i++) tick();
    check("no_writes_after_rst", n_writes - w0, 0);
    check("idle_after_rst", busy, 0);
    check("q_empty_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/geo_pixel_writer.md
GEO_PIXEL_WRITER -- requirements
Module: geo_pixel_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, coordinate buffer entries (power of two, >=2).
REQ-002 Parameter ADDR_W, default 20, byte address width.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 pixel_in_rdy  in  1  coordinate valid from the line generator.
REQ-006 x_in, y_in  in  12 each, signed  pixel coordinates.
REQ-007 line_complete_in  in  1  one-cycle end-of-line pulse from the generator.
REQ-008 pause_out  out  1  backpressure to the generator's ena_pause input.
REQ-009 base_addr  in  ADDR_W  bitmap base byte address.
REQ-010 row_stride  in  16  bytes per raster row.
REQ-011 bpp_sel  in  2  pixel depth: 0=1, 1=2, 2=4, 3=8 bpp.
REQ-012 color  in  8  pixel colour, low 2^bpp_sel bits used.
REQ-013 max_x, max_y  in  12 each, unsigned  inclusive clip limits.
REQ-014 wr_req  out  1  memory write request.
REQ-015 wr_ready  in  1  memory accepts; the transfer occurs when wr_req && wr_ready.
REQ-016 wr_addr  out  ADDR_W; wr_data  out  8; wr_mask  out  8  (1 = bit written).
REQ-017 busy  out  1; done  out  1  one-cycle pulse; clip_count  out  16.

Function
REQ-018 The FIFO shall push {x_in, y_in} when pixel_in_rdy && !pause_out.
REQ-019 pause_out shall be combinational: pause_out = (count == FIFO_DEPTH).
REQ-020 A pushed entry shall be poppable from the next cycle; there is no bypass.
REQ-021 A simultaneous push and pop shall leave count unchanged.
REQ-022 The FSM shall have three states: IDLE, CALC and ISSUE.
REQ-023 In IDLE with the FIFO non-empty, the FSM shall pop one entry into x_r/y_r and go to CALC.
REQ-024 CALC shall sample the config inputs and mark the pixel clipped if x_r<0, y_r<0, x_r>max_x or y_r>max_y.
REQ-025 On a clipped pixel, CALC shall increment clip_count (saturating at 0xFFFF), issue no write and return to IDLE.
REQ-026 Otherwise CALC shall register the address as base_addr + y_r*row_stride + ((x_r<<bpp_sel)>>3), truncated to ADDR_W.
REQ-027 The bit offset shall be bo = (x_r<<bpp_sel)&7 (MSB-first pixel packing: pixel at bo occupies bits 7-bo downward).
REQ-028 wr_mask shall be ((1<<2^bpp_sel)-1) placed at offset bo, and wr_data shall be the colour placed identically, with zeros elsewhere.
REQ-029 Leaving CALC unclipped, the FSM shall set wr_req=1 and enter ISSUE.
REQ-030 Latency from pixel_in_rdy (cycle 0, FIFO empty, FSM idle) to wr_req high shall be cycle 3.
REQ-031 In ISSUE, wr_req, wr_addr, wr_data and wr_mask shall remain stable until wr_ready.
REQ-032 On the transfer, wr_req shall drop; if the FIFO is non-empty the FSM shall pop directly into CALC, else go to IDLE.
REQ-033 Peak throughput shall be one write per 2 cycles.
REQ-034 line_complete_in shall set a pending flag.
REQ-035 done shall pulse for one cycle when pending is set, the FIFO is empty and the FSM is IDLE with wr_req low; pending shall then clear.
REQ-036 The pending flag shall be set even when the line was entirely clipped.
REQ-037 busy shall be high when the FIFO is non-empty, the state is not IDLE, or pending is set.
REQ-038 Config inputs shall be held stable while busy; values are sampled only in CALC.

Reset
REQ-039 Reset shall take priority over all inputs.
REQ-040 On reset, the FIFO shall empty (count=0, pointers=0) and the FSM shall enter IDLE.
REQ-041 On reset, wr_req, done and pending shall be 0.
REQ-042 On reset, wr_addr, wr_data, wr_mask, clip_count, x_r and y_r shall be 0.
REQ-043 Reset mid-transfer shall drop wr_req on the next cycle; the write is abandoned and not retried.

Structure
REQ-044 The bpp_sel encoding, state enum and clip_count width shall live in shared package geo_pkg.
REQ-045 The FIFO shall be sub-module geo_coord_fifo, parameterised on depth and width, exposing count, full and empty.

Verification
REQ-046 Config 8bpp, base 0x1000, stride 640; pixel (3,2) -> wr_addr 0x1503, wr_mask 0xFF, wr_data=color, wr_req at cycle 3.
REQ-047 Config 1bpp, stride 80, color 1; pixel (10,0) -> wr_addr base+1, wr_mask 0x20, wr_data 0x20.
REQ-048 Hold wr_ready=0 and push 5 pixels -> pause_out high after the FIFO fills with no entry lost; release -> 5 writes in order.
REQ-049 max_x=99; pixels (-1,5), (100,5), (50,5) then line_complete_in -> 1 write, clip_count=2, done pulses once after that write.
REQ-050 Assert reset while wr_req=1 and the FIFO holds 3 entries -> next cycle wr_req=0, busy=0, pause_out=0; no writes follow.
